pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core; one instance per boundary (F/D, D/E, E/M, M/W).
- Carries instruction, PC, a configurable number of data lanes and a flag vector, plus a valid bit.
- Supports stall (hold), flush/bubble insertion with an optional PC-preserving bubble, and a saturating stall-cycle counter for hazard debug.

Parameters:
- DATA_W, 32, width of each data lane
- NUM_DATA, 3, number of data lanes (for example alu, rt_d, md)
- FLAG_W, 1, width of the flag vector (for example b_j)
- RESET_PC, 32'h0000_3000, PC value loaded at reset
- KEEP_PC_ON_BUBBLE, 1, 1: bubbles carry pc_in; 0: bubbles load RESET_PC
- CNT_W, 8, width of hold_cnt

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold all stage contents
- flush  in  1  replace stage contents with a bubble
- in_valid  in  1  upstream slot holds a real instruction
- instr_in  in  32  instruction word
- pc_in  in  32  instruction PC
- data_in  in  NUM_DATA*DATA_W  packed lanes; lane k at [k*DATA_W +: DATA_W]
- flag_in  in  FLAG_W  control flags
- out_valid  out  1  registered valid
- instr_out  out  32  registered instruction
- pc_out  out  32  registered PC
- data_out  out  NUM_DATA*DATA_W  registered lanes
- flag_out  out  FLAG_W  registered flags
- hold_cnt  out  CNT_W  consecutive stalled cycles, saturating

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately without waiting for a clock edge):
  - out_valid=0, instr_out=0, data_out=0, flag_out=0, hold_cnt=0, pc_out=RESET_PC.
  - Reset asserted in the middle of a stall or flush overrides both.
- Priority at each rising edge while reset==1: flush > stall > load.
- Flush (flush==1; stall ignored):
  - out_valid=0, instr_out=0 (NOP), data_out=0, flag_out=0.
  - pc_out = pc_in if KEEP_PC_ON_BUBBLE, else RESET_PC.
  - hold_cnt=0.
- Stall (stall==1, flush==0):
  - All payload registers and out_valid keep their values.
  - hold_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- Load (stall==0, flush==0):
  - in_valid==1: every payload register takes its input; out_valid=1.
  - in_valid==0: same result as a flush (bubble), with pc_out following the same KEEP_PC_ON_BUBBLE rule.
  - hold_cnt=0 in both cases.
- Latency: exactly one cycle from input to output on load; zero additional state beyond the listed registers.
- All outputs are driven directly from flops; no combinational path from input to output.
- Edge cases:
  - stall and flush asserted together: treated as a flush.
  - Stall released: the held value is presented for the final held cycle, then replaced by new data on the next edge.
  - NUM_DATA==1 and FLAG_W==1 must elaborate correctly.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR (32'h0000_0000)
  - DEFAULT_RESET_PC (32'h0000_3000)
  - Typedef of the stage control pair {stall, flush}, reused by the hazard unit.
- One natural sub-module: sat_counter (parametrised by CNT_W, with inc and clr inputs and asynchronous active-low reset), used for hold_cnt.

Test Plan:
- Reset pulse low mid-cycle with stall=1 → outputs go to 0/RESET_PC immediately (before the next clk edge); hold_cnt=0.
- Load in_valid=1, instr_in=32'h0043_2021, pc_in=32'h0000_3004, lanes={1,2,3}, flag_in=1 → next edge: out_valid=1 and all outputs equal the inputs.
- stall=1 for 5 cycles while the inputs change → outputs frozen at the previous values; hold_cnt counts 1..5; on release the new data loads and hold_cnt=0.
- With CNT_W=2, stall held for 6 cycles → hold_cnt sequence 1,2,3,3,3,3 (no wrap).
- flush=1 with stall=1, pc_in=32'h0000_3010 → instr_out=0, data_out=0, flag_out=0, out_valid=0, pc_out=32'h0000_3010 (KEEP_PC_ON_BUBBLE=1) or 32'h0000_3000 (KEEP_PC_ON_BUBBLE=0).
- in_valid=0 with stall=0 and flush=0 → bubble identical to the flush case; a following in_valid=1 reloads normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers and the hazard unit
// that drives their stall/flush controls.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Per-boundary control pair produced by the hazard unit.
  typedef struct packed {
    logic stall;
    logic flush;
  } stage_ctrl_t;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; used to count consecutive
// stall cycles on a pipeline boundary.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over increment; the all-ones value is sticky until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W) with stall hold,
// flush/bubble insertion and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W            = 32,
  parameter int          NUM_DATA          = 3,
  parameter int          FLAG_W            = 1,
  parameter logic [31:0] RESET_PC          = DEFAULT_RESET_PC,
  parameter bit          KEEP_PC_ON_BUBBLE = 1'b1,
  parameter int          CNT_W             = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                instr_in,
  input  logic [31:0]                pc_in,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  input  logic [FLAG_W-1:0]          flag_in,
  output logic                       out_valid,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [FLAG_W-1:0]          flag_out,
  output logic [CNT_W-1:0]           hold_cnt
);

  localparam int LANES_W = NUM_DATA * DATA_W;

  stage_ctrl_t ctrl;
  logic        bubble;
  logic        load;
  logic        hold;

  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc_q,    pc_d;
  logic [LANES_W-1:0] data_q,  data_d;
  logic [FLAG_W-1:0]  flag_q,  flag_d;

  assign ctrl = '{stall: stall, flush: flush};

  // Flush beats stall; an empty upstream slot on a load also becomes a bubble.
  assign bubble = ctrl.flush || (!ctrl.stall && !in_valid);
  assign hold   = ctrl.stall && !ctrl.flush;
  assign load   = !ctrl.flush && !ctrl.stall && in_valid;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    data_d  = data_q;
    flag_d  = flag_q;
    if (bubble) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc_d    = KEEP_PC_ON_BUBBLE ? pc_in : RESET_PC;
      data_d  = '0;
      flag_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc_d    = pc_in;
      data_d  = data_in;
      flag_d  = flag_in;
    end
  end

  // NOTE: state flops use non-blocking assignments and reset asynchronously so
  // the stage clears immediately, even mid-stall or mid-flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      flag_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      flag_q  <= flag_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc_i (hold),
    .clr_i (!hold),
    .cnt_o (hold_cnt)
  );

  assign out_valid = valid_q;
  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign data_out  = data_q;
  assign flag_out  = flag_q;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a default instance and a narrow one
// (NUM_DATA=1, CNT_W=2, KEEP_PC_ON_BUBBLE=0) share the same stimulus.
module tb_pipe_stage_reg;

  localparam int          DW  = 32;
  localparam int          ND  = 3;
  localparam int          FW  = 1;
  localparam logic [31:0] RPC = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   instr_in = '0;
  logic [31:0]   pc_in = '0;
  logic [ND*DW-1:0] data_in = '0;
  logic [FW-1:0] flag_in = '0;

  logic          v0, v1;
  logic [31:0]   i0, i1, p0, p1;
  logic [ND*DW-1:0] d0;
  logic [DW-1:0] d1;
  logic [FW-1:0] f0;
  logic          f1;
  logic [7:0]    c0;
  logic [1:0]    c1;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the stage contents.
  logic          m_valid;
  logic [31:0]   m_instr, m_pc0, m_pc1;
  logic [DW-1:0] m_lane[ND];
  logic [FW-1:0] m_flag;
  int            m_cnt0, m_cnt1;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut0 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .instr_in(instr_in), .pc_in(pc_in), .data_in(data_in), .flag_in(flag_in),
    .out_valid(v0), .instr_out(i0), .pc_out(p0), .data_out(d0), .flag_out(f0),
    .hold_cnt(c0)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .NUM_DATA(1), .FLAG_W(1), .RESET_PC(RPC),
    .KEEP_PC_ON_BUBBLE(1'b0), .CNT_W(2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .instr_in(instr_in), .pc_in(pc_in), .data_in(data_in[DW-1:0]), .flag_in(flag_in),
    .out_valid(v1), .instr_out(i1), .pc_out(p1), .data_out(d1), .flag_out(f1),
    .hold_cnt(c1)
  );

  function automatic logic [169:0] exp0();
    logic [ND*DW-1:0] d;
    for (int k = 0; k < ND; k++) d[k*DW +: DW] = m_lane[k];
    return {m_valid, m_instr, m_pc0, d, m_flag, 8'(m_cnt0)};
  endfunction

  function automatic logic [99:0] exp1();
    return {m_valid, m_instr, m_pc1, m_lane[0], m_flag, 2'(m_cnt1)};
  endfunction

  function automatic logic [169:0] act0();
    return {v0, i0, p0, d0, f0, c0};
  endfunction

  function automatic logic [99:0] act1();
    return {v1, i1, p1, d1, f1, c1};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_instr = '0; m_pc0 = RPC; m_pc1 = RPC; m_flag = '0;
    for (int k = 0; k < ND; k++) m_lane[k] = '0;
    m_cnt0 = 0; m_cnt1 = 0;
  endtask

  // Advance the model by the rules for one rising edge, then let the edge happen.
  task automatic step();
    if (flush || (!stall && !in_valid)) begin
      m_valid = 1'b0; m_instr = '0; m_flag = '0;
      for (int k = 0; k < ND; k++) m_lane[k] = '0;
      m_pc0 = pc_in; m_pc1 = RPC;
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (stall) begin
      m_cnt0 = (m_cnt0 >= 255) ? 255 : m_cnt0 + 1;
      m_cnt1 = (m_cnt1 >= 3) ? 3 : m_cnt1 + 1;
    end else begin
      m_valid = 1'b1; m_instr = instr_in; m_pc0 = pc_in; m_pc1 = pc_in; m_flag = flag_in;
      for (int k = 0; k < ND; k++) m_lane[k] = data_in[k*DW +: DW];
      m_cnt0 = 0; m_cnt1 = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    instr_in = $urandom;
    pc_in    = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    data_in  = {$urandom, $urandom, $urandom};
    flag_in  = FW'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    model_reset();
    #12;
    total++;
    if (act0() !== exp0()) begin bad++; $display("FAIL reset_dut0 got=%h want=%h", act0(), exp0()); end
    total++;
    if (act1() !== exp1()) begin bad++; $display("FAIL reset_dut1 got=%h want=%h", act1(), exp1()); end
    total++;
    if (p0 !== 32'h0000_3000) begin bad++; $display("FAIL reset_pc got=%h want=%h", p0, 32'h0000_3000); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_load();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1;
    instr_in = 32'h0043_2021; pc_in = 32'h0000_3004;
    data_in = {32'd3, 32'd2, 32'd1}; flag_in = 1'b1;
    step();
    total++;
    if (act0() !== exp0()) begin bad++; $display("FAIL load_dut0 got=%h want=%h", act0(), exp0()); end
    total++;
    if (act1() !== exp1()) begin bad++; $display("FAIL load_dut1 got=%h want=%h", act1(), exp1()); end
    total++;
    if ({v0, i0, p0, d0, f0} !== {1'b1, 32'h0043_2021, 32'h0000_3004, 32'd3, 32'd2, 32'd1, 1'b1}) begin
      bad++; $display("FAIL load_fields got=%h/%h/%h/%h/%h", v0, i0, p0, d0, f0);
    end
  endtask

  task automatic test_reset_mid_stall();
    stall = 1'b1;
    step();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (act0() !== exp0()) begin bad++; $display("FAIL midreset_dut0 got=%h want=%h", act0(), exp0()); end
    total++;
    if (act1() !== exp1()) begin bad++; $display("FAIL midreset_dut1 got=%h want=%h", act1(), exp1()); end
    #2;
    reset = 1'b1;
    stall = 1'b0;
    in_valid = 1'b1;
    rand_inputs();
    step();
  endtask

  task automatic test_stall();
    stall = 1'b1; flush = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      rand_inputs();
      in_valid = 1'($urandom);
      step();
      total++;
      if (act0() !== exp0()) begin bad++; $display("FAIL stall_dut0 k=%0d got=%h want=%h", k, act0(), exp0()); end
      total++;
      if (c0 !== 8'(k)) begin bad++; $display("FAIL stall_cnt k=%0d got=%0d want=%0d", k, c0, k); end
    end
    stall = 1'b0; in_valid = 1'b1;
    rand_inputs();
    step();
    total++;
    if (act0() !== exp0()) begin bad++; $display("FAIL release_dut0 got=%h want=%h", act0(), exp0()); end
    total++;
    if ({v0, i0, c0} !== {1'b1, instr_in, 8'd0}) begin
      bad++; $display("FAIL release_fields got=%h/%h/%0d want=1/%h/0", v0, i0, c0, instr_in);
    end
  endtask

  task automatic test_saturate();
    int seq[6] = '{1, 2, 3, 3, 3, 3};
    stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_inputs();
      step();
      total++;
      if (c1 !== 2'(seq[k])) begin bad++; $display("FAIL sat_cnt2 k=%0d got=%0d want=%0d", k, c1, seq[k]); end
    end
    for (int k = 6; k < 260; k++) step();
    total++;
    if (c0 !== 8'd255) begin bad++; $display("FAIL sat_cnt8 got=%0d want=255", c0); end
    total++;
    if (act1() !== exp1()) begin bad++; $display("FAIL sat_dut1 got=%h want=%h", act1(), exp1()); end
    stall = 1'b0; in_valid = 1'b1;
    rand_inputs();
    step();
  endtask

  task automatic test_flush();
    stall = 1'b1;
    step();
    step();
    flush = 1'b1; in_valid = 1'b1;
    rand_inputs();
    pc_in = 32'h0000_3010;
    step();
    total++;
    if (act0() !== exp0()) begin bad++; $display("FAIL flush_dut0 got=%h want=%h", act0(), exp0()); end
    total++;
    if (act1() !== exp1()) begin bad++; $display("FAIL flush_dut1 got=%h want=%h", act1(), exp1()); end
    total++;
    if ({v0, i0, d0, f0, p0, p1, c0} !== {1'b0, 32'h0, 96'h0, 1'b0, 32'h0000_3010, 32'h0000_3000, 8'd0}) begin
      bad++; $display("FAIL flush_fields got v=%h i=%h pc0=%h pc1=%h cnt=%0d", v0, i0, p0, p1, c0);
    end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_bubble();
    in_valid = 1'b1;
    rand_inputs();
    step();
    in_valid = 1'b0;
    rand_inputs();
    pc_in = 32'h0000_3020;
    step();
    total++;
    if (act0() !== exp0()) begin bad++; $display("FAIL bubble_dut0 got=%h want=%h", act0(), exp0()); end
    total++;
    if ({v0, i0, d0, p0, p1} !== {1'b0, 32'h0, 96'h0, 32'h0000_3020, 32'h0000_3000}) begin
      bad++; $display("FAIL bubble_fields got v=%h i=%h pc0=%h pc1=%h", v0, i0, p0, p1);
    end
    in_valid = 1'b1;
    rand_inputs();
    step();
    total++;
    if (act1() !== exp1()) begin bad++; $display("FAIL reload_dut1 got=%h want=%h", act1(), exp1()); end
    total++;
    if ({v0, p0} !== {1'b1, pc_in}) begin bad++; $display("FAIL reload_fields got=%h/%h want=1/%h", v0, p0, pc_in); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rand_inputs();
      stall    = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      step();
      total++;
      if (act0() !== exp0()) begin bad++; $display("FAIL rand_dut0 n=%0d got=%h want=%h", n, act0(), exp0()); end
      total++;
      if (act1() !== exp1()) begin bad++; $display("FAIL rand_dut1 n=%0d got=%h want=%h", n, act1(), exp1()); end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_reset_mid_stall();
    test_stall();
    test_saturate();
    test_flush();
    test_bubble();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_stage_reg
